// File: rtl/fifo_parity_checker.sv
// Parity checker between an upstream FIFO pop port and a consumer.
// Two-entry skid store; bad words are dropped or forwarded with a flag.
module fifo_parity_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int EVEN_ODD   = 0,
    parameter int PARITY_BIT = 0,
    parameter int DROP_ERR   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH:0]   in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_grant_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_grant_i,
    output logic                  out_err_o,
    output logic                  err_o,
    output logic [15:0]           err_count_o
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] data_q [2];
    logic [1:0]            err_q;
    logic [DATA_WIDTH-1:0] payload;
    logic                  parity_bad;
    logic                  in_xfer;
    logic                  out_xfer;
    logic                  store;

    assign payload = (PARITY_BIT != 0) ? in_data_i[DATA_WIDTH-1:0]
                                       : in_data_i[DATA_WIDTH:1];

    assign parity_bad = (^in_data_i) != (EVEN_ODD != 0);

    // Grant depends only on the state register, never on out_grant_i.
    assign in_grant_o = (state != FULL) && !rst;

    assign in_xfer  = in_valid_i && in_grant_o;
    assign out_xfer = out_valid_o && out_grant_i;
    assign store    = in_xfer && (!parity_bad || (DROP_ERR == 0));

    assign out_valid_o = (state != EMPTY);
    assign out_data_o  = data_q[0];
    assign out_err_o   = (DROP_ERR == 0) && out_valid_o && err_q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            err_q       <= '0;
            err_o       <= 1'b0;
            err_count_o <= '0;
        end else begin
            err_o <= in_xfer && parity_bad;
            if (in_xfer && parity_bad && (err_count_o != 16'hFFFF)) begin
                err_count_o <= err_count_o + 16'd1;
            end

            unique case (state)
                EMPTY: begin
                    if (store) begin
                        data_q[0] <= payload;
                        err_q[0]  <= parity_bad;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (store && out_xfer) begin
                        data_q[0] <= payload;
                        err_q[0]  <= parity_bad;
                    end else if (store) begin
                        data_q[1] <= payload;
                        err_q[1]  <= parity_bad;
                        state     <= FULL;
                    end else if (out_xfer) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    // No input can arrive here, so only the head moves.
                    if (out_xfer) begin
                        data_q[0] <= data_q[1];
                        err_q[0]  <= err_q[1];
                        state     <= ONE;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

endmodule
